// File: rtl/board_render_pipe.sv
// board_render_pipe: registered pixel-colour generator for two N x N game
// boards separated by a divider line. Board contents and display controls are
// snapshotted on frame_start; three register stages from x/y to r/g/b.
module board_render_pipe #(
  parameter int unsigned BOARD_N      = 5,
  parameter int unsigned CELL         = 58,
  parameter int unsigned FRAME        = 4,
  parameter int unsigned LINE_W       = 2,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned MAX_LEN      = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               pix_valid_i,
  input  logic [9:0]                         x,
  input  logic [9:0]                         y,
  input  logic                               frame_start,
  input  logic [2*BOARD_N*BOARD_N-1:0]       board_l,
  input  logic [2*BOARD_N*BOARD_N-1:0]       board_r,
  input  logic                               swap_i,
  input  logic                               cursor_en,
  input  logic [2:0]                         cur_row,
  input  logic [2:0]                         cur_col,
  input  logic [$clog2(MAX_LEN+1)-1:0]       cur_len,
  input  logic                               blink_en,
  output logic [7:0]                         r,
  output logic [7:0]                         g,
  output logic [7:0]                         b,
  output logic                               pix_valid_o
);

  localparam int unsigned PITCH   = CELL + FRAME;
  localparam int unsigned BOARD_W = BOARD_N * PITCH;
  localparam int unsigned XR      = BOARD_W + LINE_W;
  localparam int unsigned NBITS   = 2 * BOARD_N * BOARD_N;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [1:0] {RG_WHITE, RG_DIV, RG_LEFT, RG_RIGHT} region_t;
  typedef enum logic {PH_OFF, PH_ON} phase_t;

  // Frame snapshot registers
  logic [NBITS-1:0] snap_l, snap_r;
  logic             swap_s, cur_en_s, blink_s;
  logic [2:0]       cur_row_s, cur_col_s;
  logic [LEN_W-1:0] cur_len_s;

  // Blink state
  phase_t           phase;
  logic [CNT_W-1:0] blink_cnt;

  // Stage registers
  logic             vld1, vld2;
  region_t          region1, region2;
  logic [2:0]       row1, col1;
  logic [1:0]       cell2;
  logic             cursor2, water_alt2;

  // Latch board contents and display controls once per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_l    <= '0;
      snap_r    <= '0;
      swap_s    <= 1'b0;
      cur_en_s  <= 1'b0;
      cur_row_s <= '0;
      cur_col_s <= '0;
      cur_len_s <= '0;
      blink_s   <= 1'b0;
    end else if (frame_start) begin
      snap_l    <= board_l;
      snap_r    <= board_r;
      swap_s    <= swap_i;
      cur_en_s  <= cursor_en;
      cur_row_s <= cur_row;
      cur_col_s <= cur_col;
      cur_len_s <= cur_len;
      blink_s   <= blink_en;
    end
  end

  // Blink FSM: count frames, flip phase every BLINK_FRAMES frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= PH_OFF;
    end else if (frame_start) begin
      if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        phase     <= (phase == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 1 decode: classify the pixel and find its cell row/column
  logic [31:0] xa, ya, xr;
  logic        row_hit, lcol_hit, rcol_hit;
  logic [2:0]  row_c, lcol_c, rcol_c, col_c;
  region_t     region_c;

  // Region/cell decode from x/y
  always_comb begin
    xa       = {22'd0, x};
    ya       = {22'd0, y};
    xr       = xa - XR;
    row_hit  = 1'b0;
    lcol_hit = 1'b0;
    rcol_hit = 1'b0;
    row_c    = '0;
    lcol_c   = '0;
    rcol_c   = '0;
    for (int unsigned i = 0; i < BOARD_N; i++) begin
      if (ya >= i*PITCH + FRAME && ya < i*PITCH + CELL) begin
        row_hit = 1'b1;
        row_c   = 3'(i);
      end
      if (xa >= i*PITCH + FRAME && xa < i*PITCH + CELL) begin
        lcol_hit = 1'b1;
        lcol_c   = 3'(i);
      end
      if (xa >= XR && xr >= i*PITCH + FRAME && xr < i*PITCH + CELL) begin
        rcol_hit = 1'b1;
        rcol_c   = 3'(i);
      end
    end
    region_c = RG_WHITE;
    col_c    = '0;
    if (row_hit && lcol_hit) begin
      region_c = RG_LEFT;
      col_c    = lcol_c;
    end else if (xa >= BOARD_W && xa < XR) begin
      region_c = RG_DIV;
    end else if (row_hit && rcol_hit) begin
      region_c = RG_RIGHT;
      col_c    = rcol_c;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1    <= 1'b0;
      region1 <= RG_WHITE;
      row1    <= '0;
      col1    <= '0;
    end else begin
      vld1    <= pix_valid_i;
      region1 <= region_c;
      row1    <= row_c;
      col1    <= col_c;
    end
  end

  // Stage 2 lookup: cell state, cursor hit and water palette
  logic [6:0]       cell_idx;
  logic [NBITS-1:0] sel_board, shifted;
  logic [1:0]       cell_c;
  logic [3:0]       cur_end;
  logic             cursor_c, water_alt_c;

  // Swap and cursor decisions are resolved here so stage 3 depends only on stage 2
  always_comb begin
    cell_idx    = 7'(row1) * 7'(BOARD_N) + 7'(col1);
    sel_board   = ((region1 == RG_RIGHT) ^ swap_s) ? snap_r : snap_l;
    shifted     = sel_board >> {cell_idx, 1'b0};
    cell_c      = shifted[1:0];
    cur_end     = {1'b0, cur_col_s} + 4'(cur_len_s);
    cursor_c    = (region1 == RG_LEFT) && cur_en_s &&
                  ((phase == PH_ON) || !blink_s) &&
                  (row1 == cur_row_s) && (col1 >= cur_col_s) &&
                  ({1'b0, col1} < cur_end);
    water_alt_c = ((region1 == RG_LEFT) && swap_s) ||
                  ((region1 == RG_RIGHT) && !swap_s);
  end

  // Stage 2 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld2       <= 1'b0;
      region2    <= RG_WHITE;
      cell2      <= '0;
      cursor2    <= 1'b0;
      water_alt2 <= 1'b0;
    end else begin
      vld2       <= vld1;
      region2    <= region1;
      cell2      <= cell_c;
      cursor2    <= cursor_c;
      water_alt2 <= water_alt_c;
    end
  end

  // Stage 3 colour selection
  logic [23:0] colour_c;

  // Map region/cell state to RGB, blank when the pixel is not valid
  always_comb begin
    colour_c = 24'h000000;
    if (vld2) begin
      unique case (region2)
        RG_DIV:   colour_c = 24'h000000;
        RG_WHITE: colour_c = 24'hFFFFFF;
        default: begin
          if (cursor2) begin
            colour_c = 24'hFF8C00;
          end else begin
            unique case (cell2)
              2'b00:   colour_c = water_alt2 ? 24'h66CCFF : 24'h0000FF;
              2'b01:   colour_c = 24'h00FF00;
              2'b10:   colour_c = 24'hFF0000;
              default: colour_c = 24'hFFFF00;
            endcase
          end
        end
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r           <= '0;
      g           <= '0;
      b           <= '0;
      pix_valid_o <= 1'b0;
    end else begin
      {r, g, b}   <= colour_c;
      pix_valid_o <= vld2;
    end
  end

endmodule

// File: tb/tb_board_render_pipe.sv
// Self-checking bench for board_render_pipe: stimulus pushes expected pixels
// to a scoreboard queue, output side pops and compares three edges later.
module tb_board_render_pipe;

  localparam int N     = 5;
  localparam int CELL  = 58;
  localparam int FRAME = 4;
  localparam int LW    = 2;
  localparam int BF    = 2;
  localparam int ML    = 4;
  localparam int P     = CELL + FRAME;
  localparam int BW    = N * P;
  localparam int XR    = BW + LW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pix_valid_i = 1'b0;
  logic [9:0]      x = '0, y = '0;
  logic            frame_start = 1'b0;
  logic [2*N*N-1:0] board_l = '0, board_r = '0;
  logic            swap_i = 1'b0, cursor_en = 1'b0, blink_en = 1'b0;
  logic [2:0]      cur_row = '0, cur_col = '0;
  logic [2:0]      cur_len = '0;
  logic [7:0]      r, g, b;
  logic            pix_valid_o;

  board_render_pipe #(
    .BOARD_N(N), .CELL(CELL), .FRAME(FRAME), .LINE_W(LW),
    .BLINK_FRAMES(BF), .MAX_LEN(ML)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid_i(pix_valid_i), .x(x), .y(y),
    .frame_start(frame_start), .board_l(board_l), .board_r(board_r),
    .swap_i(swap_i), .cursor_en(cursor_en), .cur_row(cur_row),
    .cur_col(cur_col), .cur_len(cur_len), .blink_en(blink_en),
    .r(r), .g(g), .b(b), .pix_valid_o(pix_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [24:0] exp; } exp_t;
  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference shadows of what the DUT should have latched
  logic [2*N*N-1:0] m_bl, m_br;
  logic m_swap, m_cen, m_blink, m_phase;
  int   m_crow, m_ccol, m_clen, m_cnt;

  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got v=%0b rgb=%06h, want v=%0b rgb=%06h",
               tag, got[24], got[23:0], exp[24], exp[23:0]);
    end
  endtask

  task automatic model_reset();
    m_bl = '0; m_br = '0; m_swap = 0; m_cen = 0; m_blink = 0; m_phase = 0;
    m_crow = 0; m_ccol = 0; m_clen = 0; m_cnt = 0;
  endtask

  task automatic model_latch();
    m_bl = board_l; m_br = board_r; m_swap = swap_i; m_cen = cursor_en;
    m_blink = blink_en; m_crow = int'(cur_row); m_ccol = int'(cur_col);
    m_clen = int'(cur_len);
    if (m_cnt == BF - 1) begin
      m_cnt = 0;
      m_phase = ~m_phase;
    end else begin
      m_cnt++;
    end
  endtask

  function automatic logic [23:0] model(input int px, input int py);
    int row, col, ox, oy, xx;
    logic right, use_r;
    logic [2*N*N-1:0] bd;
    logic [1:0] st;
    if (px >= BW && px < XR) return 24'h000000;
    right = (px >= XR);
    xx  = right ? px - XR : px;
    row = py / P; oy = py % P;
    col = xx / P; ox = xx % P;
    if (row >= N || col >= N || ox < FRAME || ox >= CELL || oy < FRAME || oy >= CELL)
      return 24'hFFFFFF;
    if (!right && m_cen && (m_phase || !m_blink) && row == m_crow &&
        col >= m_ccol && col < m_ccol + m_clen)
      return 24'hFF8C00;
    use_r = right ^ m_swap;
    bd = use_r ? m_br : m_bl;
    st = bd[2*(row*N+col) +: 2];
    case (st)
      2'b00:   return use_r ? 24'h66CCFF : 24'h0000FF;
      2'b01:   return 24'h00FF00;
      2'b10:   return 24'hFF0000;
      default: return 24'hFFFF00;
    endcase
  endfunction

  task automatic push_zero(input string tag);
    exp_t e;
    e.tag = tag; e.exp = '0;
    exp_q.push_back(e);
  endtask

  task automatic step(input string tag, input logic v, input int px, input int py, input logic fs);
    exp_t e, o;
    pix_valid_i = v; x = 10'(px); y = 10'(py); frame_start = fs;
    if (fs) model_latch();
    e.tag = tag;
    e.exp = v ? {1'b1, model(px, py)} : 25'd0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (exp_q.size() == 3) begin
      o = exp_q.pop_front();
      chk(o.tag, {pix_valid_o, r, g, b}, o.exp);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {pix_valid_o, r, g, b}, 25'd0);
    rst = 0;
    push_zero("post_rst0");
    push_zero("post_rst1");

    step("nofs_water", 1, 4, 4, 0);

    board_l[15:14] = 2'b01;
    step("fs_a", 0, 0, 0, 1);
    step("ship", 1, 128, 66, 0);
    step("gap", 1, 61, 4, 0);
    step("divider", 1, 310, 0, 0);
    step("invalid", 0, 128, 66, 0);
    step("cell_last", 1, 57, 4, 0);
    step("cell_past", 1, 58, 4, 0);

    board_r[1:0] = 2'b11;
    step("fs_b", 0, 0, 0, 1);
    step("r_hit", 1, 316, 4, 0);
    step("r_gap", 1, 315, 4, 0);
    step("r_water", 1, 316, 70, 0);
    step("div_end", 1, 311, 4, 0);
    step("r_beyond", 1, XR + BW, 4, 0);

    board_l[1:0] = 2'b10;
    step("midframe", 1, 4, 4, 0);
    step("fs_c", 0, 0, 0, 1);
    step("miss", 1, 4, 4, 0);

    cursor_en = 1; cur_row = 0; cur_col = 3; cur_len = 4; blink_en = 1;
    for (int f = 0; f < 5; f++) begin
      step("fs_blink", 0, 0, 0, 1);
      step("cur_c3", 1, 3*P + 10, 10, 0);
      step("cur_c4", 1, 4*P + 10, 10, 0);
      step("cur_c2", 1, 2*P + 10, 10, 0);
      step("cur_row1", 1, 4*P + 10, P + 10, 0);
    end

    blink_en = 0;
    step("fs_solid", 0, 0, 0, 1);
    step("solid_a", 1, 4*P + 10, 10, 0);
    step("fs_solid2", 0, 0, 0, 1);
    step("solid_b", 1, 3*P + 10, 10, 0);

    cur_row = 5;
    step("fs_row5", 0, 0, 0, 1);
    step("row_oob", 1, 3*P + 10, 10, 0);

    cur_row = 0; cur_len = 0;
    step("fs_len0", 0, 0, 0, 1);
    step("len_zero", 1, 3*P + 10, 10, 0);

    cur_col = 4; cur_len = 4;
    step("fs_clip", 0, 0, 0, 1);
    step("clip_in", 1, 4*P + 10, 10, 0);
    step("clip_right", 1, XR + 10, 10, 0);

    cursor_en = 0; swap_i = 1;
    step("fs_swap", 0, 0, 0, 1);
    step("swap_lw", 1, 4, 70, 0);
    step("swap_rw", 1, 316, 70, 0);
    step("swap_l0", 1, 4, 4, 0);
    step("swap_r0", 1, 316, 4, 0);

    for (int i = 0; i < 3; i++) step("pre_rst", 1, 316, 70, 0);
    rst = 1;
    #1;
    chk("rst_async", {pix_valid_o, r, g, b}, 25'd0);
    exp_q.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    push_zero("rel0");
    push_zero("rel1");
    step("rst_water_l", 1, 4, 4, 0);
    step("rst_water_r", 1, 316, 4, 0);
    step("drain0", 0, 0, 0, 0);
    step("drain1", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
